// File: rtl/gpio_seq_pkg.sv
// Shared types and register map for the GPIO APB pattern sequencer.
// Holds sequencer/APB state encodings and completer register offsets.
package gpio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_SETUP,
    CFG_ACCESS,
    WAIT_TICK,
    RD_SETUP,
    RD_ACCESS,
    WR_SETUP,
    WR_ACCESS
  } seq_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    PAT_WALK,
    PAT_COUNT,
    PAT_TOGGLE,
    PAT_MIRROR
  } pat_mode_e;

  localparam logic [7:0] CFG_BASE     = 8'h00;
  localparam logic [7:0] GPIO_IN_OFF  = 8'h90;
  localparam logic [7:0] GPIO_OUT_OFF = 8'hA0;

endpackage

// File: rtl/gpio_apb_sequencer_apb.sv
// APB3 master handshake: a one-cycle req launches setup then access
// until PREADY; request fields are registered so they stay stable.
module apb_master_fsm
  import gpio_seq_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        slverr_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  apb_state_e  state_q, state_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q  <= APB_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      APB_IDLE: begin
        if (req_i) begin
          state_d  = APB_SETUP;
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          pwrite_d = write_i;
        end
      end
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (PREADY) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  assign PSEL     = (state_q != APB_IDLE);
  assign PENABLE  = (state_q == APB_ACCESS);
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign done_o   = PENABLE & PREADY;
  assign slverr_o = done_o & PSLVERR;
  assign rdata_o  = PRDATA;

endmodule

// File: rtl/gpio_apb_sequencer.sv
// Configures GPIO pins over APB, then periodically reads GPIO_IN and
// writes the next output pattern to GPIO_OUT until stopped or errored.
module gpio_apb_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int          IO_NUM   = 4,
  parameter int          TICK_DIV = 25000000,
  parameter logic [31:0] CFG_VAL  = 32'h0000_0005
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              err,
  output logic [IO_NUM-1:0] gpio_in_snap,
  output logic [7:0]        PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [31:0] TICK_RELOAD = 32'(TICK_DIV - 1);
  localparam logic [5:0]  IDX_LAST    = 6'(IO_NUM - 1);

  seq_state_e        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [IO_NUM-1:0] pat_q, pat_d;
  logic [IO_NUM-1:0] snap_q, snap_d;
  logic [IO_NUM-1:0] nxt;
  logic [1:0]        mode_q, mode_d;
  logic              err_q, err_d;
  logic              stop_q, stop_d;
  logic              stop_any;
  logic              req, req_write;
  logic [7:0]        req_addr;
  logic [31:0]       req_wdata;
  logic              done, slverr;
  logic [31:0]       rdata;
  logic              unused_rdata;

  function automatic logic [IO_NUM-1:0] next_pat(
    input logic [IO_NUM-1:0] p,
    input logic [1:0]        m,
    input logic [IO_NUM-1:0] s
  );
    next_pat = s;
    unique case (m)
      PAT_WALK:
        next_pat = (p == '0) ? IO_NUM'(1)
                 : ((p << 1) | (p >> (IO_NUM - 1)));
      PAT_COUNT:  next_pat = p + IO_NUM'(1);
      PAT_TOGGLE: next_pat = ~p;
      PAT_MIRROR: next_pat = s;
    endcase
  endfunction

  assign nxt          = next_pat(pat_q, mode_q, snap_q);
  assign stop_any     = stop_q | stop;
  assign unused_rdata = ^rdata;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      snap_q  <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    snap_d    = snap_q;
    mode_d    = mode_q;
    err_d     = err_q;
    stop_d    = stop_q;
    req       = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    if (state_q != IDLE && stop) stop_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = CFG_SETUP;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      CFG_SETUP: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = CFG_BASE + {idx_q, 2'b00};
        req_wdata = CFG_VAL;
        state_d   = CFG_ACCESS;
      end
      CFG_ACCESS: begin
        if (done) begin
          if (slverr) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (stop_any) begin
            state_d = IDLE;
          end else if (idx_q == IDX_LAST) begin
            state_d = WAIT_TICK;
            cnt_d   = TICK_RELOAD;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = CFG_SETUP;
          end
        end
      end
      WAIT_TICK: begin
        if (stop_any) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RD_SETUP;
          mode_d  = mode;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      RD_SETUP: begin
        req      = 1'b1;
        req_addr = GPIO_IN_OFF;
        state_d  = RD_ACCESS;
      end
      RD_ACCESS: begin
        if (done) begin
          if (slverr) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            snap_d  = rdata[IO_NUM-1:0];
            state_d = stop_any ? IDLE : WR_SETUP;
          end
        end
      end
      WR_SETUP: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = GPIO_OUT_OFF;
        req_wdata = 32'(nxt);
        state_d   = WR_ACCESS;
      end
      WR_ACCESS: begin
        if (done) begin
          if (slverr) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            pat_d   = nxt;
            cnt_d   = TICK_RELOAD;
            state_d = stop_any ? IDLE : WAIT_TICK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a stop request is consumed by any return to IDLE
    if (state_d == IDLE) stop_d = 1'b0;
  end

  apb_master_fsm u_apb (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .req_i    (req),
    .write_i  (req_write),
    .addr_i   (req_addr),
    .wdata_i  (req_wdata),
    .done_o   (done),
    .slverr_o (slverr),
    .rdata_o  (rdata),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign gpio_in_snap = snap_q;

endmodule
